// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
//   One input bit is consumed per clock. The last result is held stable for a
//   multiplexed display. Values above 10^DIGITS-1 saturate to all nines and
//   raise ovf.
//
// Parameters
//   IN_W    width of the binary input (4..32)
//   DIGITS  BCD digits presented on bcd (1..9)
//
// Ports
//   clk        system clock
//   resetn     asynchronous active-low reset
//   num_bit    binary value, sampled only when in_valid && in_ready
//   in_valid   conversion request
//   in_ready   high in IDLE
//   bcd        packed BCD result, digit i at [4i+3:4i], digit 0 least significant
//   ovf        last result exceeded 10^DIGITS-1
//   out_valid  one-cycle pulse when bcd/ovf/blank update
//   blank      leading-zero blank mask
//
// Optional feature
//   BCD_BLANK_EN  when defined, blank is registered with bcd. When it is not
//                 defined, blank is tied to zero and no blank logic exists.

module bin_to_bcd_seq #(
  parameter int IN_W   = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [IN_W-1:0]       num_bit,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic                  out_valid,
  output logic [DIGITS-1:0]     blank
);

  // Number of decimal digits needed to hold 2^w-1.
  function automatic int calc_ni(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    while (v != 64'd0) begin
      v = v / 64'd10;
      n++;
    end
    return n;
  endfunction

  localparam int NI = calc_ni(IN_W);
  // The accumulator is never narrower than the output. Any padding digits
  // stay zero.
  localparam int NA = (NI > DIGITS) ? NI : DIGITS;
  localparam int CW = $clog2(IN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [IN_W-1:0]   sr;
  logic [4*NA-1:0]   acc, adj;
  logic [CW-1:0]     cnt;
  logic              accept;
  logic              hi_nz;
  logic [4*DIGITS-1:0] res_bcd;

  assign accept = in_valid && in_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(IN_W - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready = (state == IDLE);
  end

  // Add 3 to every digit >= 5 before the shift. Each digit is corrected
  // independently, so no carry passes between digits.
  always_comb begin
    adj = acc;
    for (int i = 0; i < NA; i++)
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
  end

  // Overflow means that a digit above the presented window is nonzero.
  generate
    if (NA > DIGITS) begin : g_hi
      assign hi_nz = |acc[4*NA-1:4*DIGITS];
    end else begin : g_nohi
      assign hi_nz = 1'b0;
    end
  endgenerate

  assign res_bcd = hi_nz ? {DIGITS{4'h9}} : acc[4*DIGITS-1:0];

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr  <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sr  <= num_bit;
          acc <= '0;
          cnt <= '0;
        end
        SHIFT: begin
          acc <= {adj[4*NA-2:0], sr[IN_W-1]};
          sr  <= {sr[IN_W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Results are registered on the edge that leaves DONE and then held
  // until the next conversion completes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bcd       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state == DONE);
      if (state == DONE) begin
        bcd <= res_bcd;
        ovf <= hi_nz;
      end
    end
  end

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] res_blank;

  // Walk down from the top digit. blank[i] stays set while every digit
  // at index i or above is zero. Digit 0 is never blanked, and no digit
  // is blanked for a saturated result.
  always_comb begin
    logic zero_above;
    res_blank  = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above   = zero_above & (res_bcd[4*i +: 4] == 4'd0);
      res_blank[i] = zero_above & ~hi_nz;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)             blank <= '0;
    else if (state == DONE)  blank <= res_blank;
  end
`else
  assign blank = '0;
`endif

endmodule
